imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
- Boot-time stage directly upstream of the single-cycle RV32I core.
- Receives a program image as a byte stream over a valid/ready handshake, assembles little-endian 32-bit words and writes them into instruction memory.
- Holds the core in reset until the image is fully loaded, then releases it so the core fetches from PC = 0.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; capacity DEPTH = 2**ADDR_W words.
- LEN_W, 16, width of the word-count header field; must be at least ADDR_W+1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  byte stream valid.
- in_data  in  8  byte stream payload.
- in_ready  out  1  loader accepts a byte; transfer occurs when in_valid && in_ready at the rising edge.
- reload  in  1  single-cycle request to start a new load; ignored unless state is DONE or ERR.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  word address being written.
- imem_wdata  out  32  word being written.
- core_rst  out  1  reset to the processor core; high while loading.
- done  out  1  image loaded, core released.
- error  out  1  header word count exceeds DEPTH (or checksum mismatch, see optional feature).

Behaviour:
- Interface decision: one clock, clk; rst is asynchronous and active-high. All outputs are registered except in_ready, which is decoded from state.
- Reset values: state=IDLE, imem_we=0, imem_addr=0, imem_wdata=0, core_rst=1, done=0, error=0, byte counter=0, word counter=0. in_ready is 0 in IDLE.
- Image format: LEN_LO, LEN_HI (word count N, little-endian, zero-extended to LEN_W), then 4N data bytes. Byte 0 of each word goes to bits [7:0].
- States:
  - IDLE: moves to LEN_LO on the next clk unconditionally.
  - LEN_LO: in_ready=1; on accept, latch the low byte and go to LEN_HI.
  - LEN_HI: in_ready=1; on accept, latch the high byte, then:
    - N==0: go to DONE.
    - N>DEPTH: go to ERR.
    - Otherwise: go to DATA.
  - DATA: in_ready=1; bytes shift into a word register.
    - On accepting the 4th byte, in the next cycle: imem_we=1, imem_wdata=assembled word, imem_addr=word counter; the word counter then increments.
    - imem_we is high for exactly one cycle per word. No back-pressure is applied, so bytes may arrive back-to-back.
    - After the write of word N-1, go to DONE.
  - DONE: in_ready=0. core_rst goes to 0 and done goes to 1 in the cycle after the last imem_we.
  - ERR: in_ready=0, error=1, core_rst stays 1.
- imem_addr wraps modulo DEPTH. This is unreachable, because N>DEPTH is rejected; N==DEPTH is legal and writes addresses 0..DEPTH-1.
- in_valid while in_ready=0: not accepted; the byte is neither consumed nor buffered.
- reload in DONE or ERR: core_rst=1, done=0, error=0, counters cleared, go to LEN_LO next cycle. reload in any other state is ignored.
- Reset mid-load: all state returns to reset values, and any partial word is discarded. Memory contents already written are not cleared.

Optional Feature:
- Macro: IMEM_BOOT_CHECKSUM_EN.
- Defined:
  - One extra byte follows the data: the XOR of all 4N data bytes (for N==0, expected value 0x00).
  - An added CHECK state accepts that byte.
  - Match: go to DONE.
  - Mismatch: go to ERR with error=1; core_rst stays 1.
- Undefined: no trailing byte; go from the last write straight to DONE. The CHECK state and XOR register are absent.

Decomposition:
- Shared package holds:
  - State enum: IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERR.
  - Byte-lane constants.
  - Default ADDR_W and LEN_W.
- One natural sub-module, byte_word_packer:
  - Function: 2-bit lane counter plus 32-bit shift register.
  - Outputs: word_valid pulse and word.
  - Clear input for reload and reset.
- The FSM stays in the top module.

Test Plan:
- Back-to-back stream 0x02,0x00, then bytes 13 05 00 00 93 05 10 00 → imem_we pulses exactly twice: addr0=0x00000513, addr1=0x00100593. core_rst falls and done rises the cycle after the second write; in_ready=0 afterwards.
- Same image with in_valid toggled every other cycle → identical writes and values; no byte is dropped or duplicated.
- Header N=0 → no imem_we; DONE and core_rst=0 within 1 cycle of accepting LEN_HI.
- ADDR_W=4, header N=17 → ERR, error=1, core_rst stays 1, no writes. Then reload followed by a valid N=1 image → error clears and done=1.
- rst pulsed after 6 of 8 data bytes, then a full 1-word image → only the new word is written, at addr 0; no stale bytes appear in it.
- With IMEM_BOOT_CHECKSUM_EN, 1-word image 0x00000513 → checksum byte 0x16 gives DONE; checksum byte 0x17 gives ERR and core_rst stays 1.

Source files
------------

// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Build option IMEM_BOOT_CHECKSUM_EN adds a trailing XOR checksum byte to the image.
package imem_boot_loader_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int LEN_W_DEF  = 16;

    localparam int         BYTE_W    = 8;
    localparam logic [1:0] LANE_LAST = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CHECK,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/imem_boot_loader_byte_word_packer.sv
// Packs an accepted byte stream into little-endian 32-bit words.
// word_valid pulses for one cycle after the fourth byte of each word is accepted.
module imem_boot_loader_byte_word_packer
    import imem_boot_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              word_valid,
    output logic [31:0]       word
);

    logic [1:0]  lane_reg;
    logic [31:0] shift_reg;
    logic        word_valid_reg;

    // Right shift puts the first byte of a word in bits [7:0] once four bytes are in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_reg       <= 2'd0;
            shift_reg      <= 32'd0;
            word_valid_reg <= 1'b0;
        end else if (clear) begin
            lane_reg       <= 2'd0;
            shift_reg      <= 32'd0;
            word_valid_reg <= 1'b0;
        end else begin
            word_valid_reg <= byte_valid && (lane_reg == LANE_LAST);
            if (byte_valid) begin
                shift_reg <= {byte_data, shift_reg[31:BYTE_W]};
                lane_reg  <= lane_reg + 2'd1;
            end
        end
    end

    assign word_valid = word_valid_reg;
    assign word       = shift_reg;

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed byte image, writes it into instruction
// memory and then releases the core from reset. IMEM_BOOT_CHECKSUM_EN adds a checksum byte.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              done,
    output logic              error
);

    localparam logic [LEN_W:0] DEPTH_L = (LEN_W+1)'(2**ADDR_W);

    state_t            state_reg, state_next;
    logic [7:0]        len_lo_reg;
    logic [LEN_W-1:0]  len_reg, len_next;
    logic [LEN_W+1:0]  byte_cnt_reg;
    logic [LEN_W-1:0]  word_cnt_reg;
    logic              core_rst_reg, done_reg, error_reg;
    logic              accept, data_accept, reload_take, data_full, last_word;
    logic              pk_valid;
    logic [31:0]       pk_word;
    logic [15:0]       hdr;
`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [7:0]        xor_reg;
`endif

    assign hdr         = {in_data, len_lo_reg};
    assign len_next    = LEN_W'(hdr);
    assign accept      = in_valid && in_ready;
    assign data_accept = accept && (state_reg == DATA);
    assign reload_take = reload && ((state_reg == DONE) || (state_reg == ERR));
    // Stop taking bytes once the whole payload is in, so a trailing byte is never
    // mistaken for data while the final word write is still pending.
    assign data_full   = (byte_cnt_reg == {len_reg, 2'b00});
    assign last_word   = pk_valid && (word_cnt_reg == len_reg - LEN_W'(1));

    always_comb begin
        in_ready = 1'b0;
        case (state_reg)
            LEN_LO, LEN_HI: in_ready = 1'b1;
            DATA:           in_ready = !data_full;
            CHECK:          in_ready = 1'b1;
            default:        in_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:   state_next = LEN_LO;
            LEN_LO: if (accept) state_next = LEN_HI;
            LEN_HI: begin
                if (accept) begin
                    if (len_next == '0) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                        state_next = CHECK;
`else
                        state_next = DONE;
`endif
                    end else if ({1'b0, len_next} > DEPTH_L) begin
                        state_next = ERR;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (last_word) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                    state_next = CHECK;
`else
                    state_next = DONE;
`endif
                end
            end
`ifdef IMEM_BOOT_CHECKSUM_EN
            CHECK: if (accept) state_next = (in_data == xor_reg) ? DONE : ERR;
`endif
            DONE, ERR: if (reload) state_next = LEN_LO;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            len_lo_reg   <= 8'd0;
            len_reg      <= '0;
            byte_cnt_reg <= '0;
            word_cnt_reg <= '0;
            core_rst_reg <= 1'b1;
            done_reg     <= 1'b0;
            error_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept && (state_reg == LEN_LO)) len_lo_reg <= in_data;
            if (accept && (state_reg == LEN_HI)) len_reg <= len_next;
            if (reload_take) begin
                byte_cnt_reg <= '0;
                word_cnt_reg <= '0;
            end else begin
                if (data_accept) byte_cnt_reg <= byte_cnt_reg + 1'b1;
                if (pk_valid)    word_cnt_reg <= word_cnt_reg + 1'b1;
            end
            // Status flags follow the state being entered, so they settle with it.
            core_rst_reg <= (state_next != DONE);
            done_reg     <= (state_next == DONE);
            error_reg    <= (state_next == ERR);
        end
    end

`ifdef IMEM_BOOT_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xor_reg <= 8'd0;
        end else if (reload_take) begin
            xor_reg <= 8'd0;
        end else if (data_accept) begin
            xor_reg <= xor_reg ^ in_data;
        end
    end
`endif

    imem_boot_loader_byte_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (reload_take),
        .byte_valid (data_accept),
        .byte_data  (in_data),
        .word_valid (pk_valid),
        .word       (pk_word)
    );

    assign imem_we    = pk_valid;
    assign imem_wdata = pk_word;
    assign imem_addr  = word_cnt_reg[ADDR_W-1:0];
    assign core_rst   = core_rst_reg;
    assign done       = done_reg;
    assign error      = error_reg;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader (ADDR_W=4): random images against a write-list model.
// Defining IMEM_BOOT_CHECKSUM_EN makes the bench append checksum bytes and test mismatches.
module tb_imem_boot_loader;

    localparam int ADDR_W = 4;
    localparam int LEN_W  = 16;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              reload;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_rst;
    logic              done;
    logic              error;

    imem_boot_loader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          last_we_cyc = -100;
    int          done_rise_cyc = -100;
    int          last_send_cyc = -100;
    logic        done_prev = 1'b0;
    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [31:0] img [0:DEPTH-1];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write strobe must match the next expected write.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            last_we_cyc = cyc;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: addr=%h data=%h with none expected", imem_addr, imem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(imem_addr), 32'(mon_e.addr));
                check("wr_data", imem_wdata, mon_e.data);
                $display("write addr=%h data=%h", imem_addr, imem_wdata);
            end
        end
        if (done === 1'b1 && done_prev !== 1'b1) done_rise_cyc = cyc;
        done_prev = done;
    end

    task automatic send_byte(input logic [7:0] b, input bit gappy);
        int guard = 0;
        bit sent = 0;
        while (!sent) begin
            @(negedge clk);
            if (gappy && $urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = b;
                sent     = (in_ready === 1'b1);
            end
            guard++;
            if (!sent && guard > 50) begin
                miscompares++;
                $display("FAIL send_timeout: byte %h never accepted, in_ready=%b", b, in_ready);
                $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
                $fatal(1, "stalled");
            end
        end
        last_send_cyc = cyc;
    endtask

    // Sends an n-word image from img[], then checks the final status.
    task automatic run_image(input int n, input bit gappy, input bit ck_bad);
        logic [15:0] hdr;
        logic [7:0]  ck;
        logic [7:0]  b;
        bit          ok;
        bit          expect_err;
        int          guard;
        hdr = 16'(n);
        ck  = 8'h00;
        ok  = (n <= DEPTH);
        expect_err = !ok || ck_bad;
        done_rise_cyc = -100;
        if (ok) begin
            for (int i = 0; i < n; i++) exp_q.push_back('{addr: ADDR_W'(i), data: img[i]});
        end
        send_byte(hdr[7:0], gappy);
        send_byte(hdr[15:8], gappy);
        if (ok) begin
            for (int i = 0; i < n; i++) begin
                for (int k = 0; k < 4; k++) begin
                    b  = img[i][8*k +: 8];
                    ck = ck ^ b;
                    send_byte(b, gappy);
                end
            end
        end
`ifdef IMEM_BOOT_CHECKSUM_EN
        if (ok) send_byte(ck_bad ? (ck ^ 8'h01) : ck, gappy);
`endif
        // Junk held on the bus must never be consumed.
        repeat (3) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'hA5;
        end
        @(negedge clk);
        in_valid = 1'b0;
        guard = 0;
        while (done !== 1'b1 && error !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        $display("image n=%0d gappy=%0d ck_bad=%0d -> done=%b error=%b core_rst=%b", n, gappy, ck_bad, done, error, core_rst);
        check("done", 32'(done), 32'(!expect_err));
        check("error", 32'(error), 32'(expect_err));
        check("core_rst", 32'(core_rst), 32'(expect_err));
        check("in_ready_after", 32'(in_ready), 32'd0);
        check("writes_pending", 32'(exp_q.size()), 32'd0);
`ifndef IMEM_BOOT_CHECKSUM_EN
        if (!expect_err) begin
            if (n > 0) check("done_latency", 32'(done_rise_cyc), 32'(last_we_cyc + 1));
            else       check("done_latency_n0", 32'(done_rise_cyc), 32'(last_send_cyc + 1));
        end
`endif
    endtask

    task automatic do_reload();
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        check("reload_done", 32'(done), 32'd0);
        check("reload_error", 32'(error), 32'd0);
        check("reload_core_rst", 32'(core_rst), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_we"}, 32'(imem_we), 32'd0);
        check({tag, "_addr"}, 32'(imem_addr), 32'd0);
        check({tag, "_wdata"}, imem_wdata, 32'd0);
        check({tag, "_core_rst"}, 32'(core_rst), 32'd1);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        reload = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;

        // Directed two-word image, back-to-back then with gaps.
        img[0] = 32'h00000513;
        img[1] = 32'h00100593;
        run_image(2, 1'b0, 1'b0);
        do_reload();
        run_image(2, 1'b1, 1'b0);
        do_reload();

        // Empty image and over-capacity header.
        run_image(0, 1'b0, 1'b0);
        do_reload();
        run_image(17, 1'b0, 1'b0);
        do_reload();

        // Full-capacity image.
        for (int i = 0; i < DEPTH; i++) img[i] = $urandom;
        run_image(DEPTH, 1'b0, 1'b0);
        do_reload();

        // Random images.
        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) img[i] = $urandom;
            run_image(n, bit'($urandom_range(0, 1)), 1'b0);
            do_reload();
        end

        // Reset after 6 of 8 data bytes: only the first word gets written.
        img[0] = $urandom;
        img[1] = $urandom;
        exp_q.push_back('{addr: ADDR_W'(0), data: img[0]});
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        for (int j = 0; j < 6; j++) send_byte(img[j / 4][8*(j % 4) +: 8], 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_values("midload_reset");
        check("midload_first_word", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        img[0] = $urandom;
        run_image(1, 1'b0, 1'b0);

`ifdef IMEM_BOOT_CHECKSUM_EN
        do_reload();
        img[0] = 32'h00000513;
        run_image(1, 1'b0, 1'b0);
        do_reload();
        run_image(1, 1'b1, 1'b1);
`endif

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
